// File: rtl/sha_t_unit.sv
// sha_t_unit: two-stage SHA compression term out0 = S(x) + F(x,y,z) [+ in3] with run/done and valid/ready flow.
module sha_t_unit #(
  parameter int DATA_W = 32,
  parameter int ROT_W  = 6,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              running,
  output logic              done,
  input  logic [LEN_W-1:0]  len,
  input  logic [2:0]        mode,
  input  logic [ROT_W-1:0]  constant_00,
  input  logic [ROT_W-1:0]  constant_01,
  input  logic [ROT_W-1:0]  constant_02,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out0
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [2:0] mode_q, mode_d;
  logic [ROT_W-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic s1v_q, s1v_d, ov_q, ov_d, done_q, done_d;
  logic [DATA_W-1:0] s_q, s_d, f_q, f_d, a_q, a_d, out0_q, out0_d;
  logic adv2, in_fire, out_fire;
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [ROT_W-1:0] c);
    int unsigned r;
    r = 32'(c) % DATA_W;
    return (x >> r) | (x << (DATA_W - r));
  endfunction
  function automatic logic [DATA_W-1:0] shr(input logic [DATA_W-1:0] x, input logic [ROT_W-1:0] c);
    int unsigned r;
    r = 32'(c) % DATA_W;
    return x >> r;
  endfunction
  assign running   = state_q == RUN;
  assign done      = done_q;
  assign out_valid = ov_q;
  assign out0      = out0_q;
  assign adv2      = !ov_q || out_ready;
  assign in_ready  = running && in_cnt_q < len_q && (!s1v_q || adv2);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = ov_q && out_ready;
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    c0_d      = c0_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    in_cnt_d  = in_fire ? in_cnt_q + 1'b1 : in_cnt_q;
    out_cnt_d = out_fire ? out_cnt_q + 1'b1 : out_cnt_q;
    done_d    = 1'b0;
    if (state_q == IDLE && run) begin
      len_d     = len;
      mode_d    = mode;
      c0_d      = constant_00;
      c1_d      = constant_01;
      c2_d      = constant_02;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      state_d   = len == '0 ? IDLE : RUN;
      done_d    = len == '0;
    end
    if (out_fire && out_cnt_q + 1'b1 == len_q) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    s1v_d  = in_fire || (s1v_q && !adv2);
    s_d    = in_fire ? rotr(in0, c0_q) ^ rotr(in0, c1_q) ^ (mode_q[2] ? shr(in0, c2_q) : rotr(in0, c2_q)) : s_q;
    f_d    = !in_fire ? f_q : mode_q[0] ? (in0 & in1) ^ (~in0 & in2) : (in0 & in1) ^ (in0 & in2) ^ (in1 & in2);
    a_d    = !in_fire ? a_q : mode_q[1] ? in3 : '0;
    ov_d   = adv2 ? s1v_q : ov_q;
    out0_d = adv2 && s1v_q ? s_q + f_q + a_q : out0_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      mode_q    <= '0;
      c0_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      s1v_q     <= 1'b0;
      s_q       <= '0;
      f_q       <= '0;
      a_q       <= '0;
      ov_q      <= 1'b0;
      out0_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      c0_q      <= c0_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      s1v_q     <= s1v_d;
      s_q       <= s_d;
      f_q       <= f_d;
      a_q       <= a_d;
      ov_q      <= ov_d;
      out0_q    <= out0_d;
    end
  end
endmodule

// File: tb/tb_sha_t_unit.sv
// tb_sha_t_unit: directed vectors for the 32- and 64-bit configurations of sha_t_unit.
module tb_sha_t_unit;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic run = 0, in_valid = 0, out_ready = 0;
  logic [15:0] len = '0;
  logic [2:0] mode = '0;
  logic [5:0] c0 = '0, c1 = '0, c2 = '0;
  logic [31:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic running, done, in_ready, out_valid;
  logic [31:0] out0;
  logic run64 = 0, iv64 = 0, or64 = 0;
  logic [15:0] len64 = '0;
  logic [2:0] mode64 = '0;
  logic [5:0] k0 = '0, k1 = '0, k2 = '0;
  logic [63:0] x64 = '0, y64 = '0, z64 = '0, a64 = '0;
  logic r64, d64, ir64, ov64;
  logic [63:0] o64;
  int n_vec = 0, n_bad = 0;
  logic [31:0] vx[16], vy[16], vz[16], va[16];
  sha_t_unit dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .done(done), .len(len), .mode(mode),
    .constant_00(c0), .constant_01(c1), .constant_02(c2), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .out_valid(out_valid), .out_ready(out_ready), .out0(out0)
  );
  sha_t_unit #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .run(run64), .running(r64), .done(d64), .len(len64), .mode(mode64),
    .constant_00(k0), .constant_01(k1), .constant_02(k2), .in_valid(iv64), .in_ready(ir64),
    .in0(x64), .in1(y64), .in2(z64), .in3(a64), .out_valid(ov64), .out_ready(or64), .out0(o64)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] m32(input logic [31:0] x, y, z, a, input logic [2:0] md, input int a0, a1, a2);
    logic [63:0] xx;
    logic [31:0] s, f;
    xx = {x, x};
    s = 32'(xx >> (a0 % 32)) ^ 32'(xx >> (a1 % 32)) ^ (md[2] ? x >> (a2 % 32) : 32'(xx >> (a2 % 32)));
    f = md[0] ? (x & y) ^ (~x & z) : (x & y) ^ (x & z) ^ (y & z);
    return s + f + (md[1] ? a : 32'h0);
  endfunction
  task automatic stream(input int n, input logic [2:0] md, input int a0, a1, a2, input bit tog, input int rerun_at);
    int idx = 0, oidx = 0, cyc = 0;
    bit seen = 0;
    run = 1; len = 16'(n); mode = md; c0 = 6'(a0); c1 = 6'(a1); c2 = 6'(a2);
    tick;
    run = 0;
    chk("running", running, 1);
    while (!seen && cyc < 100) begin
      in_valid = 1;
      in0 = vx[idx % 16]; in1 = vy[idx % 16]; in2 = vz[idx % 16]; in3 = va[idx % 16];
      out_ready = tog ? (cyc % 2 == 0) : 1'b1;
      run = cyc == rerun_at;
      if (cyc == rerun_at) begin
        len = 1; mode = ~md;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        chk("out0", out0, m32(vx[oidx % 16], vy[oidx % 16], vz[oidx % 16], va[oidx % 16], md, a0, a1, a2));
        oidx++;
      end
      if (done) seen = 1;
      tick;
      cyc++;
    end
    in_valid = 0; out_ready = 1; run = 0;
    chk("accepted", idx, n);
    chk("results", oidx, n);
    chk("done_seen", seen, 1);
    chk("idle", running, 0);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    tick; tick;
    rst = 0;
    tick;
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out0", out0, 0);
    chk("rst_out0_64", o64, 0);
    run = 1; len = 1; mode = 3'b000; c0 = 2; c1 = 13; c2 = 22;
    tick;
    run = 0;
    chk("t1_running", running, 1);
    in_valid = 1; in0 = 32'h6a09e667; in1 = 32'hbb67ae85; in2 = 32'h3c6ef372; in3 = 32'h0; out_ready = 1;
    #1 chk("t1_in_ready", in_ready, 1);
    tick;
    in_valid = 0;
    chk("t1_lat1", out_valid, 0);
    tick;
    chk("t1_valid", out_valid, 1);
    chk("t1_out0", out0, 32'h08909ae5);
    chk("t1_done_early", done, 0);
    tick;
    chk("t1_done", done, 1);
    chk("t1_running_off", running, 0);
    tick;
    chk("t1_done_pulse", done, 0);
    vx[0] = 32'h510e527f; vy[0] = 32'h9b05688c; vz[0] = 32'h1f83d9ab; va[0] = 32'h0;
    stream(1, 3'b011, 6, 11, 25, 0, -1);
    for (int i = 0; i < 16; i++) begin
      vx[i] = 32'h9e3779b9 * (i + 1);
      vy[i] = {vx[i][15:0], vx[i][31:16]} ^ 32'hdeadbeef;
      vz[i] = 32'h01234567 + 32'h11111111 * i;
      va[i] = 32'h01010101 * i + 32'h80000000;
    end
    stream(8, 3'b110, 7, 18, 3, 1, -1);
    run64 = 1; len64 = 1; mode64 = 3'b100; k0 = 1; k1 = 8; k2 = 7;
    tick;
    run64 = 0; iv64 = 1; x64 = 64'h1; y64 = 64'h0; z64 = 64'h0; or64 = 1;
    tick;
    iv64 = 0;
    tick;
    chk("t4_valid", ov64, 1);
    chk("t4_out0", o64, 64'h8100000000000000);
    tick;
    chk("t4_done", d64, 1);
    run = 1; len = 0; in_valid = 1;
    tick;
    run = 0;
    chk("t5_running", running, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_done", done, 1);
    tick;
    chk("t5_done_pulse", done, 0);
    in_valid = 0;
    stream(4, 3'b001, 2, 13, 22, 0, 2);
    run = 1; len = 4; mode = 3'b000;
    tick;
    run = 0; in_valid = 1; out_ready = 0;
    tick; tick;
    chk("t6_full", in_ready, 0);
    chk("t6_held", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_running", running, 0);
    chk("t6_rst_out0", out0, 0);
    tick;
    rst = 0; in_valid = 0; out_ready = 1;
    tick;
    stream(3, 3'b000, 2, 13, 22, 1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
